// File: rtl/flash_read_arbiter.sv
// Two-port round-robin arbiter that serialises byte/half/word read requests
// into single-byte flash reads and returns a little-endian assembled response.
module flash_read_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [1:0]            req0_size,
  output logic                  req0_ready,
  output logic                  rsp0_valid,
  output logic [31:0]           rsp0_data,
  output logic                  rsp0_err,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [1:0]            req1_size,
  output logic                  req1_ready,
  output logic                  rsp1_valid,
  output logic [31:0]           rsp1_data,
  output logic                  rsp1_err,
  output logic [ADDR_WIDTH-1:0] flash_addr,
  output logic                  flash_read_en,
  output logic [2:0]            flash_byte_size,
  input  logic [7:0]            flash_data,
  input  logic                  flash_ready
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StRead, StGap, StResp} state_e;

  state_e                r_state;
  state_e                w_state_next;
  logic                  r_last_grant;
  logic                  r_port;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [1:0]            r_idx;
  logic [1:0]            r_last_idx;
  logic [31:0]           r_data;
  logic [TmoW-1:0]       r_tmo;
  logic [31:0]           r_rsp0_data;
  logic                  r_rsp0_err;
  logic [31:0]           r_rsp1_data;
  logic                  r_rsp1_err;

  logic                  w_idle;
  logic                  w_sel_port;
  logic                  w_accept;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [1:0]            w_size;
  logic                  w_misalign;
  logic                  w_tmo_hit;
  logic [31:0]           w_data_upd;
  logic                  w_capture;
  logic                  w_finish;
  logic                  w_fin_err;
  logic                  w_fin_port;
  logic [31:0]           w_fin_data;

  // On a tie the port that did not win last time gets the grant.
  assign w_idle     = (r_state == StIdle);
  assign w_sel_port = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
  assign w_accept   = w_idle && (req0_valid || req1_valid);
  assign req0_ready = w_idle && req0_valid && !w_sel_port;
  assign req1_ready = w_idle && req1_valid && w_sel_port;

  assign w_addr     = w_sel_port ? req1_addr : req0_addr;
  assign w_size     = w_sel_port ? req1_size : req0_size;
  assign w_misalign = (w_size == 2'd3) ||
                      ((w_size == 2'd1) && w_addr[0]) ||
                      ((w_size == 2'd2) && (w_addr[1:0] != 2'b00));
  assign w_tmo_hit  = (r_tmo == TmoW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_data_upd = r_data;
    w_data_upd[{r_idx, 3'b000} +: 8] = flash_data;
  end

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_finish     = 1'b0;
    w_fin_err    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (w_misalign) begin
            w_state_next = StResp;
            w_finish     = 1'b1;
            w_fin_err    = 1'b1;
          end else begin
            w_state_next = StRead;
          end
        end
      end
      StRead: begin
        if (flash_ready) begin
          w_capture = 1'b1;
          if (r_idx == r_last_idx) begin
            w_state_next = StResp;
            w_finish     = 1'b1;
          end else begin
            w_state_next = StGap;
          end
        end else if (w_tmo_hit) begin
          w_state_next = StResp;
          w_finish     = 1'b1;
          w_fin_err    = 1'b1;
        end
      end
      StGap:   w_state_next = StRead;
      StResp:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  assign w_fin_port = w_idle ? w_sel_port : r_port;
  assign w_fin_data = w_fin_err ? 32'd0 : w_data_upd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_grant <= 1'b1;
      r_port       <= 1'b0;
      r_base       <= '0;
      r_idx        <= 2'd0;
      r_last_idx   <= 2'd0;
      r_data       <= 32'd0;
      r_tmo        <= '0;
      r_rsp0_data  <= 32'd0;
      r_rsp0_err   <= 1'b0;
      r_rsp1_data  <= 32'd0;
      r_rsp1_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_port       <= w_sel_port;
        r_last_grant <= w_sel_port;
        r_base       <= w_addr;
        r_idx        <= 2'd0;
        r_last_idx   <= (w_size == 2'd0) ? 2'd0 : (w_size == 2'd1) ? 2'd1 : 2'd3;
        r_data       <= 32'd0;
        r_tmo        <= '0;
      end
      if (r_state == StRead) begin
        if (w_capture) begin
          r_data <= w_data_upd;
          r_idx  <= r_idx + 2'd1;
          r_tmo  <= '0;
        end else begin
          r_tmo  <= r_tmo + 1'b1;
        end
      end
      if (w_finish) begin
        if (w_fin_port) begin
          r_rsp1_data <= w_fin_data;
          r_rsp1_err  <= w_fin_err;
        end else begin
          r_rsp0_data <= w_fin_data;
          r_rsp0_err  <= w_fin_err;
        end
      end
    end
  end

  assign flash_read_en   = (r_state == StRead);
  assign flash_addr      = r_base + ADDR_WIDTH'(r_idx);
  assign flash_byte_size = 3'd1;
  assign rsp0_valid      = (r_state == StResp) && !r_port;
  assign rsp1_valid      = (r_state == StResp) && r_port;
  assign rsp0_data       = r_rsp0_data;
  assign rsp0_err        = r_rsp0_err;
  assign rsp1_data       = r_rsp1_data;
  assign rsp1_err        = r_rsp1_err;

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Directed bench for flash_read_arbiter with a byte-wide flash model that
// answers after a programmable number of wait cycles.
module tb_flash_read_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_addr, req1_addr;
  logic [1:0]  req0_size, req1_size;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_data, rsp1_data;
  logic        rsp0_err, rsp1_err;
  logic [31:0] flash_addr;
  logic        flash_read_en;
  logic [2:0]  flash_byte_size;
  logic [7:0]  flash_data;
  logic        flash_ready;

  logic [7:0]  mem [0:255];
  int          f_wait = 0;
  logic        f_stall = 1'b0;
  int          fcnt = 0;
  int          re_cnt = 0;
  logic [31:0] re_addr [0:15];

  int checks = 0;
  int errors = 0;

  flash_read_arbiter #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_size(req0_size),
    .req0_ready(req0_ready), .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
    .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_size(req1_size),
    .req1_ready(req1_ready), .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
    .rsp1_err(rsp1_err),
    .flash_addr(flash_addr), .flash_read_en(flash_read_en),
    .flash_byte_size(flash_byte_size), .flash_data(flash_data),
    .flash_ready(flash_ready)
  );

  always #5 clk = ~clk;

  // Flash model: ready once read_en has been high for f_wait full cycles.
  always @(posedge clk) begin
    if (!flash_read_en) fcnt <= 0;
    else                fcnt <= fcnt + 1;
  end
  assign flash_ready = flash_read_en && (fcnt >= f_wait) && !f_stall;
  assign flash_data  = mem[flash_addr[7:0]];

  always @(posedge flash_read_en) begin
    re_addr[re_cnt % 16] <= flash_addr;
    re_cnt <= re_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Issues one request and measures latency (cycles after the accept edge).
  task automatic run_req(input bit port, input logic [31:0] addr, input logic [1:0] size,
                         output int lat, output logic [31:0] data, output logic err,
                         output int nen, output bit other, output bit acc_ok);
    int base;
    int k;
    base   = re_cnt;
    other  = 1'b0;
    lat    = -1;
    data   = 32'hxxxx_xxxx;
    err    = 1'bx;
    @(posedge clk); #1;
    if (port) begin req1_valid = 1'b1; req1_addr = addr; req1_size = size; end
    else      begin req0_valid = 1'b1; req0_addr = addr; req0_size = size; end
    k = 0;
    @(negedge clk);
    while (!(port ? req1_ready : req0_ready) && k < 50) begin
      @(negedge clk);
      k++;
    end
    acc_ok = port ? req1_ready : req0_ready;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (port ? rsp0_valid : rsp1_valid) other = 1'b1;
      if (port ? rsp1_valid : rsp0_valid) begin
        lat  = c;
        data = port ? rsp1_data : rsp0_data;
        err  = port ? rsp1_err : rsp0_err;
        break;
      end
    end
    nen = re_cnt - base;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req0_valid = 1'b0; req0_addr = '0; req0_size = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_size = '0;
    #12;
    checks++;
    if (flash_read_en !== 1'b0) begin errors++;
      $display("FAIL reset_read_en got %b want 0", flash_read_en); end
    checks++;
    if (flash_byte_size !== 3'd1) begin errors++;
      $display("FAIL reset_byte_size got %0d want 1", flash_byte_size); end
    checks++;
    if (flash_addr !== 32'd0) begin errors++;
      $display("FAIL reset_flash_addr got %h want 0", flash_addr); end
    checks++;
    if ({rsp0_valid, rsp1_valid, rsp0_err, rsp1_err} !== 4'b0000) begin errors++;
      $display("FAIL reset_rsp_flags got %b want 0000",
               {rsp0_valid, rsp1_valid, rsp0_err, rsp1_err}); end
    checks++;
    if ({rsp0_data, rsp1_data} !== 64'd0) begin errors++;
      $display("FAIL reset_rsp_data got %h %h want 0 0", rsp0_data, rsp1_data); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_word();
    int lat, nen, base;
    logic [31:0] d;
    logic e;
    bit oth, ok;
    mem[8'h10] = 8'h11; mem[8'h11] = 8'h22; mem[8'h12] = 8'h33; mem[8'h13] = 8'h44;
    base = re_cnt;
    run_req(1'b0, 32'h10, 2'd2, lat, d, e, nen, oth, ok);
    checks++;
    if (lat !== 8) begin errors++; $display("FAIL word_latency got %0d want 8", lat); end
    checks++;
    if (d !== 32'h4433_2211) begin errors++;
      $display("FAIL word_data got %h want 44332211", d); end
    checks++;
    if (e !== 1'b0) begin errors++; $display("FAIL word_err got %b want 0", e); end
    checks++;
    if (nen !== 4) begin errors++; $display("FAIL word_read_edges got %0d want 4", nen); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (re_addr[(base + i) % 16] !== 32'h10 + i) begin errors++;
        $display("FAIL word_addr%0d got %h want %h", i, re_addr[(base + i) % 16], 32'h10 + i);
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (rsp0_data !== 32'h4433_2211) begin errors++;
      $display("FAIL word_hold got %h want 44332211", rsp0_data); end
  endtask

  task automatic test_tie();
    int order [0:2];
    int na;
    int a;
    bit both;
    bit got0;
    logic [31:0] d0, d1;
    mem[8'h00] = 8'h01; mem[8'h01] = 8'h02; mem[8'h02] = 8'h03; mem[8'h03] = 8'h04;
    mem[8'h05] = 8'hAB;
    na = 0; both = 1'b0; got0 = 1'b0;
    d0 = 32'hxxxx_xxxx; d1 = 32'hxxxx_xxxx;
    order[0] = -1; order[1] = -1; order[2] = -1;
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_addr = 32'h0; req0_size = 2'd2;
    req1_valid = 1'b1; req1_addr = 32'h5; req1_size = 2'd0;
    for (int c = 0; c < 200 && na < 3; c++) begin
      @(negedge clk);
      if (req0_ready && req1_ready) both = 1'b1;
      a = req0_ready ? 0 : (req1_ready ? 1 : -1);
      if (rsp1_valid) d1 = rsp1_data;
      @(posedge clk); #1;
      if (a >= 0) begin
        order[na] = a;
        na++;
        if (a == 1) req1_valid = 1'b0;
        if (na == 3) req0_valid = 1'b0;
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int c = 0; c < 50 && !got0; c++) begin
      @(negedge clk);
      if (rsp0_valid) begin d0 = rsp0_data; got0 = 1'b1; end
    end
    checks++;
    if (order[0] !== 0) begin errors++; $display("FAIL tie_first got %0d want 0", order[0]); end
    checks++;
    if (order[1] !== 1) begin errors++; $display("FAIL tie_second got %0d want 1", order[1]); end
    checks++;
    if (order[2] !== 0) begin errors++; $display("FAIL tie_third got %0d want 0", order[2]); end
    checks++;
    if (both !== 1'b0) begin errors++; $display("FAIL tie_both_ready got 1 want 0"); end
    checks++;
    if (d1 !== 32'h0000_00AB) begin errors++;
      $display("FAIL tie_p1_data got %h want 000000ab", d1); end
    checks++;
    if (d0 !== 32'h0403_0201) begin errors++;
      $display("FAIL tie_p0_data got %h want 04030201", d0); end
  endtask

  task automatic test_misalign();
    int lat, nen;
    logic [31:0] d;
    logic e;
    bit oth, ok;
    run_req(1'b1, 32'h3, 2'd1, lat, d, e, nen, oth, ok);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL half_mis_latency got %0d want 1", lat); end
    checks++;
    if ({e, d} !== {1'b1, 32'd0}) begin errors++;
      $display("FAIL half_mis_rsp got err=%b data=%h want err=1 data=0", e, d); end
    checks++;
    if (nen !== 0) begin errors++; $display("FAIL half_mis_read_en got %0d want 0", nen); end
    checks++;
    if (oth !== 1'b0) begin errors++; $display("FAIL half_mis_other_rsp got 1 want 0"); end
    run_req(1'b1, 32'h8, 2'd3, lat, d, e, nen, oth, ok);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL size3_latency got %0d want 1", lat); end
    checks++;
    if ({e, d} !== {1'b1, 32'd0}) begin errors++;
      $display("FAIL size3_rsp got err=%b data=%h want err=1 data=0", e, d); end
    checks++;
    if (nen !== 0) begin errors++; $display("FAIL size3_read_en got %0d want 0", nen); end
  endtask

  task automatic test_wait();
    int lat, nen;
    logic [31:0] d;
    logic e;
    bit oth, ok;
    mem[8'h20] = 8'hCD; mem[8'h21] = 8'hAB;
    f_wait = 3;
    run_req(1'b0, 32'h20, 2'd1, lat, d, e, nen, oth, ok);
    f_wait = 0;
    checks++;
    if (lat !== 10) begin errors++; $display("FAIL wait_latency got %0d want 10", lat); end
    checks++;
    if (d !== 32'h0000_ABCD) begin errors++;
      $display("FAIL wait_data got %h want 0000abcd", d); end
    checks++;
    if (nen !== 2) begin errors++; $display("FAIL wait_read_edges got %0d want 2", nen); end
  endtask

  task automatic test_timeout();
    int lat, nen;
    logic [31:0] d;
    logic e;
    bit oth, ok;
    f_stall = 1'b1;
    run_req(1'b0, 32'h40, 2'd0, lat, d, e, nen, oth, ok);
    checks++;
    if (flash_read_en !== 1'b0) begin errors++;
      $display("FAIL tmo_read_en got %b want 0", flash_read_en); end
    f_stall = 1'b0;
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL tmo_latency got %0d want 9", lat); end
    checks++;
    if ({e, d} !== {1'b1, 32'd0}) begin errors++;
      $display("FAIL tmo_rsp got err=%b data=%h want err=1 data=0", e, d); end
    mem[8'h41] = 8'h5A;
    run_req(1'b0, 32'h41, 2'd0, lat, d, e, nen, oth, ok);
    checks++;
    if ({lat, e, d} !== {32'd2, 1'b0, 32'h5A}) begin errors++;
      $display("FAIL tmo_recover got lat=%0d err=%b data=%h want lat=2 err=0 data=5a",
               lat, e, d); end
  endtask

  task automatic test_reset_mid();
    int base, k;
    bit seen;
    f_wait = 3;
    base = re_cnt;
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_addr = 32'h10; req0_size = 2'd2;
    k = 0;
    @(negedge clk);
    while (!req0_ready && k < 20) begin @(negedge clk); k++; end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    k = 0;
    while (re_cnt < base + 2 && k < 100) begin @(posedge clk); k++; end
    @(negedge clk);
    checks++;
    if (flash_read_en !== 1'b1) begin errors++;
      $display("FAIL rstmid_in_read got %b want 1", flash_read_en); end
    rst = 1'b0;
    #1;
    checks++;
    if ({flash_read_en, rsp0_valid} !== 2'b00) begin errors++;
      $display("FAIL rstmid_drop got read_en=%b rsp0=%b want 0 0", flash_read_en, rsp0_valid); end
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rsp0_valid || rsp1_valid) seen = 1'b1;
    end
    rst = 1'b1;
    f_wait = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp0_valid || rsp1_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_no_rsp got 1 want 0"); end
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_addr = 32'h0; req0_size = 2'd0;
    req1_valid = 1'b1; req1_addr = 32'h5; req1_size = 2'd0;
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin errors++;
      $display("FAIL rstmid_tie got %b%b want 10", req0_ready, req1_ready); end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_tie();
    test_word();
    test_misalign();
    test_wait();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/flash_read_arbiter.md
Name: flash_read_arbiter

Overview:
- Shares the SoC's 8-bit external flash read port between two requesters: port 0 (instruction fetch) and port 1 (data load).
- Accepts byte, half or word read requests and issues the required sequence of single-byte flash reads.
- Assembles the bytes little-endian and returns one response per request.
- Sits between the core's fetch/LSU paths and the digital_flash_* pins of digital_soc.

Parameters:
ADDR_WIDTH, 32, width of request and flash addresses
TIMEOUT_CYCLES, 255, max cycles in READ waiting for flash ready before an error response

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
req0_valid  in  1  port 0 request
req0_addr  in  ADDR_WIDTH  port 0 byte address
req0_size  in  2  0=byte, 1=half, 2=word, 3=illegal
req0_ready  out  1  port 0 request accepted this cycle
rsp0_valid  out  1  port 0 response pulse
rsp0_data  out  32  port 0 read data, zero-extended
rsp0_err  out  1  port 0 error, qualified by rsp0_valid
req1_valid, req1_addr, req1_size, req1_ready, rsp1_valid, rsp1_data, rsp1_err  same as port 0, for port 1
flash_addr  out  ADDR_WIDTH  byte address to flash
flash_read_en  out  1  flash read strobe
flash_byte_size  out  3  constant 3'd1
flash_data  in  8  flash read byte
flash_ready  in  1  flash data valid

Behaviour:
- Reset (async, rst=0) values: all outputs 0, except flash_byte_size=1. State=IDLE, last_grant=1, so port 0 wins the first tie. Reset mid-transfer drops flash_read_en immediately; no response is generated.
- States: IDLE, READ, GAP, RESP.
- IDLE:
  - reqN_ready is combinational and is only asserted in IDLE.
  - Grant is round-robin: if both ports are valid, grant the port that is not last_grant; otherwise grant the single valid port.
  - Accept = valid && ready. On accept, latch port, addr, size and byte count (1/2/4) and update last_grant.
- Alignment check at accept:
  - Half with addr[0]!=0, word with addr[1:0]!=0, or size=3 is an error. Go to RESP with err=1 and data=0; the flash is untouched.
  - Otherwise go to READ.
- READ:
  - flash_read_en=1; flash_addr = base + byte index.
  - If flash_ready is sampled 1: capture flash_data into byte lane [index]. On the last byte go to RESP; otherwise increment index and go to GAP.
  - Timeout counter counts cycles in READ. When it reaches TIMEOUT_CYCLES without ready, go to RESP with err=1, data=0.
- GAP: flash_read_en=0 for exactly one cycle, then READ. This guarantees a fresh read_en rising edge per byte.
- RESP:
  - flash_read_en=0. Assert rspN_valid for one cycle on the granted port only; other port's rsp signals stay 0. Return to IDLE.
  - rspN_data/err hold their values until that port's next response.
- Data: byte lanes fill LSB-first. Unread upper lanes are 0 (zero-extend); sign extension is the requester's job.
- Latency, zero-wait flash, accept at cycle 0: byte rsp at cycle 2, half at 4, word at 8. Each extra flash wait cycle adds 1. Error (misaligned) rsp at cycle 1.
- Back-to-back: the next accept is possible in the cycle after RESP (IDLE).
- The address counter wraps modulo 2^ADDR_WIDTH with no error.

Test Plan:
- Word read port 0, addr 0x10, flash bytes 11,22,33,44, zero-wait -> rsp0_valid at cycle 8, rsp0_data=0x44332211, err=0; flash_read_en sees 4 separate rising edges at addrs 0x10-0x13.
- Both ports request simultaneously after reset (p0 word @0x0, p1 byte @0x5=0xAB) -> p0 served first; p1 accepted next IDLE, rsp1_data=0x000000AB; on the next tie p1 wins.
- Half read @0x3 on port 1 -> rsp1_valid 1 cycle after accept, rsp1_err=1, data=0, flash_read_en never asserted; size=3 gives the same result.
- flash_ready delayed 3 cycles per byte on half read @0x20 (bytes CD,AB) -> rsp at cycle 10, data=0x0000ABCD.
- flash_ready held 0 with TIMEOUT_CYCLES=8 -> error rsp after 8 READ cycles, read_en dropped, next request serviced normally.
- rst pulled low during byte 2 of a word read -> flash_read_en=0 at once, no rsp pulse; after release, the first tie goes to port 0.
